// File: rtl/c_ext_align_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_c_ext_pkg
// Purpose  : Shared types and constants for the IF-stage C-extension
//            alignment sequencer and the interface that carries its signals.
// Revision : 1.0 - initial release
// ============================================================================
package if_c_ext_pkg;

  // Alignment sequencing states
  typedef enum logic [1:0] {
    NORMAL     = 2'd0,
    SPAN_WAIT  = 2'd1,
    SPAN_READY = 2'd2
  } align_state_e;

  // PC advance amounts reported to the IF-stage PC logic
  localparam logic [2:0] PC_INC_NONE = 3'd0;
  localparam logic [2:0] PC_INC_HALF = 3'd2;
  localparam logic [2:0] PC_INC_WORD = 3'd4;

  // Low two opcode bits of a full 32-bit (non-compressed) parcel
  localparam logic [1:0] RVC_OPCODE_32BIT = 2'b11;

  // True when a parcel's low opcode bits mark it as a compressed instruction
  function automatic logic is_rvc_opcode(input logic [1:0] opc);
    return (opc != RVC_OPCODE_32BIT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/c_ext_align_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : c_ext_align_sequencer_if
// Purpose  : Bundle of IF-stage signals exchanged between the PC/aligner side
//            (master) and the C-extension alignment sequencer (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface c_ext_align_sequencer_if #(
  parameter int XLEN = 32
);
  // Driven by the IF stage / aligner
  logic            i_stall;
  logic            i_flush;
  logic [XLEN-1:0] i_pc_reg;
  logic [31:0]     i_instr;
  logic [31:0]     i_effective_instr;
  logic            i_is_compressed;

  // Driven by the sequencer
  logic            o_prev_was_compressed_at_lo;
  logic            o_prev_was_compressed_at_lo_saved;
  logic            o_stall_registered;
  logic [31:0]     o_instr_buffer;
  logic            o_spanning_wait_for_fetch;
  logic            o_spanning_in_progress;
  logic [15:0]     o_spanning_buffer;
  logic [15:0]     o_spanning_second_half;
  logic            o_use_buffer_after_spanning;
  logic            o_span_fetch_req;
  logic [2:0]      o_pc_increment;

  modport master (
    output i_stall, i_flush, i_pc_reg, i_instr, i_effective_instr, i_is_compressed,
    input  o_prev_was_compressed_at_lo, o_prev_was_compressed_at_lo_saved,
           o_stall_registered, o_instr_buffer, o_spanning_wait_for_fetch,
           o_spanning_in_progress, o_spanning_buffer, o_spanning_second_half,
           o_use_buffer_after_spanning, o_span_fetch_req, o_pc_increment
  );

  modport slave (
    input  i_stall, i_flush, i_pc_reg, i_instr, i_effective_instr, i_is_compressed,
    output o_prev_was_compressed_at_lo, o_prev_was_compressed_at_lo_saved,
           o_stall_registered, o_instr_buffer, o_spanning_wait_for_fetch,
           o_spanning_in_progress, o_spanning_buffer, o_spanning_second_half,
           o_use_buffer_after_spanning, o_span_fetch_req, o_pc_increment
  );

endinterface
`default_nettype wire

// File: rtl/c_ext_align_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : c_ext_align_sequencer
// Purpose  : Drives the C-extension state inputs of the IF-stage aligner:
//            low-half compressed flag, buffered fetch word, the multi-cycle
//            sequence for a 32-bit instruction spanning two fetch words, and
//            stall save of the alignment flag. Also produces the PC increment
//            and the spanning-fetch request. Only registered state feeds the
//            aligner, so no combinational loop is formed.
// Revision : 1.0 - initial release
// ============================================================================
module c_ext_align_sequencer
  import if_c_ext_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int SPAN_WAIT_CYCLES = 1
) (
  input  wire logic              i_clk,
  input  wire logic              i_rst_n,
  c_ext_align_sequencer_if.slave bus
);

  // Counter load value: number of extra advance cycles spent in SPAN_WAIT
  localparam logic [1:0] WAIT_INIT = 2'(SPAN_WAIT_CYCLES - 1);

  align_state_e r_state, w_state_nxt;
  logic [1:0]   r_wait_cnt, w_wait_cnt_nxt;
  logic         r_prev_lo, w_prev_lo_nxt;
  logic         r_prev_lo_saved, w_prev_lo_saved_nxt;
  logic         r_stall_reg;
  logic [31:0]  r_instr_buffer, w_instr_buffer_nxt;
  logic [15:0]  r_span_buf, w_span_buf_nxt;
  logic [15:0]  r_span_second, w_span_second_nxt;
  logic         r_use_buf, w_use_buf_nxt;
  logic         w_fetch_req;
  logic [2:0]   w_pc_inc;
  logic [XLEN-1:0] w_pc;

  assign w_pc = bus.i_pc_reg;

  // State register and all sequencing registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= NORMAL;
      r_wait_cnt      <= 2'd0;
      r_prev_lo       <= 1'b0;
      r_prev_lo_saved <= 1'b0;
      r_stall_reg     <= 1'b0;
      r_instr_buffer  <= 32'd0;
      r_span_buf      <= 16'd0;
      r_span_second   <= 16'd0;
      r_use_buf       <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_wait_cnt      <= w_wait_cnt_nxt;
      r_prev_lo       <= w_prev_lo_nxt;
      r_prev_lo_saved <= w_prev_lo_saved_nxt;
      r_stall_reg     <= bus.i_stall;
      r_instr_buffer  <= w_instr_buffer_nxt;
      r_span_buf      <= w_span_buf_nxt;
      r_span_second   <= w_span_second_nxt;
      r_use_buf       <= w_use_buf_nxt;
    end
  end

  // Next-state and combinational outputs; priority is flush, then stall, then advance
  always_comb begin
    w_state_nxt         = r_state;
    w_wait_cnt_nxt      = r_wait_cnt;
    w_prev_lo_nxt       = r_prev_lo;
    w_prev_lo_saved_nxt = r_prev_lo_saved;
    w_instr_buffer_nxt  = r_instr_buffer;
    w_span_buf_nxt      = r_span_buf;
    w_span_second_nxt   = r_span_second;
    w_use_buf_nxt       = r_use_buf;
    w_fetch_req         = 1'b0;
    w_pc_inc            = PC_INC_NONE;

    if (bus.i_flush) begin
      // Redirect: drop any partial span; the fetch buffer is left untouched
      w_state_nxt         = NORMAL;
      w_wait_cnt_nxt      = 2'd0;
      w_prev_lo_nxt       = 1'b0;
      w_prev_lo_saved_nxt = 1'b0;
      w_span_buf_nxt      = 16'd0;
      w_span_second_nxt   = 16'd0;
      w_use_buf_nxt       = 1'b0;
    end else if (bus.i_stall) begin
      // Snapshot the alignment flag only on the first stalled cycle
      if (!r_stall_reg) begin
        w_prev_lo_saved_nxt = r_prev_lo;
      end
    end else begin
      case (r_state)
        NORMAL: begin
          w_use_buf_nxt = 1'b0;
          if (bus.i_is_compressed) begin
            w_pc_inc = PC_INC_HALF;
            if (!w_pc[1]) begin
              // Upper half of this word is still pending: keep the word
              w_prev_lo_nxt      = 1'b1;
              w_instr_buffer_nxt = bus.i_effective_instr;
            end else begin
              w_prev_lo_nxt = 1'b0;
            end
          end else if (!w_pc[1]) begin
            w_prev_lo_nxt = 1'b0;
            w_pc_inc      = PC_INC_WORD;
          end else begin
            // 32-bit instruction starting at the upper half: fetch next word
            w_span_buf_nxt = bus.i_effective_instr[31:16];
            w_prev_lo_nxt  = 1'b0;
            w_fetch_req    = 1'b1;
            w_wait_cnt_nxt = WAIT_INIT;
            w_state_nxt    = SPAN_WAIT;
          end
        end
        SPAN_WAIT: begin
          if (r_wait_cnt == 2'd0) begin
            w_span_second_nxt  = bus.i_instr[15:0];
            w_instr_buffer_nxt = bus.i_instr;
            w_state_nxt        = SPAN_READY;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt - 2'd1;
          end
        end
        SPAN_READY: begin
          // The next parcel is the upper half of the word just fetched
          w_pc_inc      = PC_INC_WORD;
          w_use_buf_nxt = 1'b1;
          w_prev_lo_nxt = 1'b0;
          w_state_nxt   = NORMAL;
        end
        default: begin
          w_state_nxt = NORMAL;
        end
      endcase
    end
  end

  assign bus.o_prev_was_compressed_at_lo       = r_prev_lo;
  assign bus.o_prev_was_compressed_at_lo_saved = r_prev_lo_saved;
  assign bus.o_stall_registered                = r_stall_reg;
  assign bus.o_instr_buffer                    = r_instr_buffer;
  assign bus.o_spanning_wait_for_fetch         = (r_state == SPAN_WAIT);
  assign bus.o_spanning_in_progress            = (r_state == SPAN_READY);
  assign bus.o_spanning_buffer                 = r_span_buf;
  assign bus.o_spanning_second_half            = r_span_second;
  assign bus.o_use_buffer_after_spanning       = r_use_buf;
  assign bus.o_span_fetch_req                  = i_rst_n & w_fetch_req;
  assign bus.o_pc_increment                    = i_rst_n ? w_pc_inc : PC_INC_NONE;

  // A span fetch can only be launched from the idle alignment state
  a_fetch_req_normal : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    bus.o_span_fetch_req |-> (r_state == NORMAL));

  // The two span phases are mutually exclusive
  a_span_onehot : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(bus.o_spanning_wait_for_fetch && bus.o_spanning_in_progress));

  // The PC must be fully defined whenever the sequencer is running
  a_pc_known : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !$isunknown(w_pc));

endmodule
`default_nettype wire

// File: tb/tb_c_ext_align_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_c_ext_align_sequencer
// Purpose  : Directed self-checking bench for c_ext_align_sequencer. One
//            instance uses a one-cycle span wait, a second uses three.
// Revision : 1.0 - initial release
// ============================================================================
module tb_c_ext_align_sequencer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  c_ext_align_sequencer_if #(.XLEN(32)) bus1 ();
  c_ext_align_sequencer_if #(.XLEN(32)) bus3 ();

  c_ext_align_sequencer #(.XLEN(32), .SPAN_WAIT_CYCLES(1)) u_dut1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus1)
  );

  c_ext_align_sequencer #(.XLEN(32), .SPAN_WAIT_CYCLES(3)) u_dut3 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus3)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the dut1 fetch-side inputs
  task automatic drive1(input logic [31:0] pc, input logic [31:0] eff,
                        input logic [31:0] instr, input logic comp);
    bus1.i_pc_reg          = pc;
    bus1.i_effective_instr = eff;
    bus1.i_instr           = instr;
    bus1.i_is_compressed   = comp;
  endtask

  // Watchdog: the directed sequence is far shorter than this
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus1.i_stall = 1'b0;
    bus1.i_flush = 1'b0;
    drive1(32'h100, 32'h0000_0000, 32'h0000_0000, 1'b0);
    bus3.i_stall = 1'b0;
    bus3.i_flush = 1'b1;
    bus3.i_pc_reg = 32'h200;
    bus3.i_effective_instr = 32'h0;
    bus3.i_instr = 32'h0;
    bus3.i_is_compressed = 1'b1;

    // ---------------- reset state ----------------
    tick();
    tick();
    check_eq("rst_pc_inc", 32'(bus1.o_pc_increment), 32'd0);
    check_eq("rst_prev_lo", 32'(bus1.o_prev_was_compressed_at_lo), 32'd0);
    check_eq("rst_buffer", bus1.o_instr_buffer, 32'd0);
    check_eq("rst_fetch_req", 32'(bus1.o_span_fetch_req), 32'd0);
    check_eq("rst_stall_reg", 32'(bus1.o_stall_registered), 32'd0);
    rst_n = 1'b1;

    // ---------------- two compressed parcels ----------------
    drive1(32'h100, 32'h4501_4505, 32'h4501_4505, 1'b1);
    #1;
    check_eq("c1_pc_inc", 32'(bus1.o_pc_increment), 32'd2);
    tick();
    check_eq("c1_prev_lo", 32'(bus1.o_prev_was_compressed_at_lo), 32'd1);
    check_eq("c1_buffer", bus1.o_instr_buffer, 32'h4501_4505);
    drive1(32'h102, 32'h4501_4505, 32'h4501_4505, 1'b1);
    #1;
    check_eq("c2_pc_inc", 32'(bus1.o_pc_increment), 32'd2);
    tick();
    check_eq("c2_prev_lo", 32'(bus1.o_prev_was_compressed_at_lo), 32'd0);

    // ---------------- span, one wait cycle ----------------
    drive1(32'h102, 32'h0513_4501, 32'h0513_4501, 1'b0);
    #1;
    check_eq("sp_fetch_req", 32'(bus1.o_span_fetch_req), 32'd1);
    check_eq("sp_start_pc_inc", 32'(bus1.o_pc_increment), 32'd0);
    tick();
    check_eq("sp_buffer", 32'(bus1.o_spanning_buffer), 32'h0513);
    check_eq("sp_wait", 32'(bus1.o_spanning_wait_for_fetch), 32'd1);
    check_eq("sp_fetch_req_once", 32'(bus1.o_span_fetch_req), 32'd0);
    drive1(32'h102, 32'h0513_4501, 32'hABCD_0045, 1'b0);
    #1;
    check_eq("sp_wait_pc_inc", 32'(bus1.o_pc_increment), 32'd0);
    tick();
    check_eq("sp_second", 32'(bus1.o_spanning_second_half), 32'h0045);
    check_eq("sp_refill", bus1.o_instr_buffer, 32'hABCD_0045);
    check_eq("sp_in_prog", 32'(bus1.o_spanning_in_progress), 32'd1);
    check_eq("sp_wait_off", 32'(bus1.o_spanning_wait_for_fetch), 32'd0);
    #1;
    check_eq("sp_ready_pc_inc", 32'(bus1.o_pc_increment), 32'd4);
    tick();
    check_eq("sp_use_buf", 32'(bus1.o_use_buffer_after_spanning), 32'd1);
    check_eq("sp_done", 32'(bus1.o_spanning_in_progress), 32'd0);
    drive1(32'h106, 32'hABCD_0045, 32'hABCD_0045, 1'b1);
    #1;
    check_eq("sp_after_pc_inc", 32'(bus1.o_pc_increment), 32'd2);
    tick();
    check_eq("sp_use_buf_clr", 32'(bus1.o_use_buffer_after_spanning), 32'd0);

    // ---------------- stall with prev_lo=1 ----------------
    drive1(32'h108, 32'h1111_2222, 32'h1111_2222, 1'b1);
    tick();
    check_eq("st_prev_lo", 32'(bus1.o_prev_was_compressed_at_lo), 32'd1);
    bus1.i_stall = 1'b1;
    drive1(32'h10A, 32'h3333_4444, 32'h3333_4444, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("st_pc_inc", 32'(bus1.o_pc_increment), 32'd0);
      tick();
      check_eq("st_saved", 32'(bus1.o_prev_was_compressed_at_lo_saved), 32'd1);
      check_eq("st_prev_hold", 32'(bus1.o_prev_was_compressed_at_lo), 32'd1);
      check_eq("st_buf_hold", bus1.o_instr_buffer, 32'h1111_2222);
    end
    bus1.i_stall = 1'b0;
    #1;
    check_eq("st_reg_lag", 32'(bus1.o_stall_registered), 32'd1);
    check_eq("st_rel_pc_inc", 32'(bus1.o_pc_increment), 32'd2);
    tick();
    check_eq("st_reg_clr", 32'(bus1.o_stall_registered), 32'd0);
    check_eq("st_rel_prev_lo", 32'(bus1.o_prev_was_compressed_at_lo), 32'd0);

    // ---------------- flush mid SPAN_WAIT, three wait cycles ----------------
    bus3.i_flush = 1'b0;
    bus3.i_pc_reg = 32'h202;
    bus3.i_effective_instr = 32'h1234_0001;
    bus3.i_instr = 32'h1234_0001;
    bus3.i_is_compressed = 1'b0;
    #1;
    check_eq("fl_fetch_req", 32'(bus3.o_span_fetch_req), 32'd1);
    tick();
    check_eq("fl_wait_a", 32'(bus3.o_spanning_wait_for_fetch), 32'd1);
    check_eq("fl_span_buf", 32'(bus3.o_spanning_buffer), 32'h1234);
    bus3.i_instr = 32'h9999_8888;
    tick();
    check_eq("fl_wait_b", 32'(bus3.o_spanning_wait_for_fetch), 32'd1);
    bus3.i_flush = 1'b1;
    tick();
    check_eq("fl_wait_clr", 32'(bus3.o_spanning_wait_for_fetch), 32'd0);
    check_eq("fl_in_prog", 32'(bus3.o_spanning_in_progress), 32'd0);
    check_eq("fl_span_buf_clr", 32'(bus3.o_spanning_buffer), 32'd0);
    check_eq("fl_second_clr", 32'(bus3.o_spanning_second_half), 32'd0);
    check_eq("fl_prev_lo", 32'(bus3.o_prev_was_compressed_at_lo), 32'd0);
    check_eq("fl_req_gated", 32'(bus3.o_span_fetch_req), 32'd0);
    check_eq("fl_pc_inc", 32'(bus3.o_pc_increment), 32'd0);

    // ---------------- stall + flush together in SPAN_READY ----------------
    drive1(32'h10E, 32'h0077_0001, 32'h0077_0001, 1'b0);
    tick();
    drive1(32'h10E, 32'h0077_0001, 32'h5555_6666, 1'b0);
    tick();
    check_eq("sf_in_prog", 32'(bus1.o_spanning_in_progress), 32'd1);
    check_eq("sf_second", 32'(bus1.o_spanning_second_half), 32'h6666);
    bus1.i_stall = 1'b1;
    bus1.i_flush = 1'b1;
    #1;
    check_eq("sf_pc_inc", 32'(bus1.o_pc_increment), 32'd0);
    tick();
    check_eq("sf_normal", 32'(bus1.o_spanning_in_progress), 32'd0);
    check_eq("sf_stall_reg", 32'(bus1.o_stall_registered), 32'd1);
    check_eq("sf_span_clr", 32'(bus1.o_spanning_buffer), 32'd0);
    check_eq("sf_use_buf", 32'(bus1.o_use_buffer_after_spanning), 32'd0);
    check_eq("sf_buf_hold", bus1.o_instr_buffer, 32'h5555_6666);
    check_eq("sf_saved_clr", 32'(bus1.o_prev_was_compressed_at_lo_saved), 32'd0);
    bus1.i_stall = 1'b0;
    bus1.i_flush = 1'b0;

    // ---------------- async reset mid SPAN_READY ----------------
    drive1(32'h112, 32'h0099_0001, 32'h0099_0001, 1'b0);
    tick();
    drive1(32'h112, 32'h0099_0001, 32'h7777_8888, 1'b0);
    tick();
    check_eq("ar_in_prog", 32'(bus1.o_spanning_in_progress), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_in_prog_clr", 32'(bus1.o_spanning_in_progress), 32'd0);
    check_eq("ar_buffer_clr", bus1.o_instr_buffer, 32'd0);
    check_eq("ar_span_clr", 32'(bus1.o_spanning_buffer), 32'd0);
    check_eq("ar_second_clr", 32'(bus1.o_spanning_second_half), 32'd0);
    check_eq("ar_pc_inc", 32'(bus1.o_pc_increment), 32'd0);
    rst_n = 1'b1;
    drive1(32'h100, 32'h4501_4505, 32'h4501_4505, 1'b1);
    tick();
    check_eq("ar_wait_post", 32'(bus1.o_spanning_wait_for_fetch), 32'd0);
    check_eq("ar_prog_post", 32'(bus1.o_spanning_in_progress), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/c_ext_align_sequencer.md
Name: c_ext_align_sequencer

Overview:
- Sequential state controller that drives the C-extension state inputs of the IF-stage instruction aligner.
- Tracks four things:
  - whether the previous parcel was compressed at the low halfword;
  - the buffered fetch word;
  - the multi-cycle sequence for a 32-bit instruction that spans two fetch words;
  - stall save/restore of the alignment state.
- Also produces the PC increment (0/2/4) and the spanning-fetch request for the IF-stage PC logic.
- Sits in the IF stage beside the aligner.
  - Consumes the aligner's is_compressed and effective_instr outputs.
  - Feeds back registered state only, so there is no combinational loop.

Parameters:
- XLEN, 32, architectural width; PC ports are XLEN wide.
- SPAN_WAIT_CYCLES, 1, cycles between the spanning-fetch request and valid i_instr (memory read latency), range 1..3.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_stall  in  1  pipeline stall; freezes all sequencing state
- i_flush  in  1  redirect/trap flush; clears alignment state
- i_pc_reg  in  XLEN  registered PC; only bit 1 is used
- i_instr  in  32  raw fetch word from instruction memory
- i_effective_instr  in  32  aligner-selected word (buffer or i_instr)
- i_is_compressed  in  1  aligner: current parcel is compressed
- o_prev_was_compressed_at_lo  out  1  live flag to the aligner
- o_prev_was_compressed_at_lo_saved  out  1  value captured at stall entry
- o_stall_registered  out  1  i_stall delayed one cycle
- o_instr_buffer  out  32  buffered fetch word
- o_spanning_wait_for_fetch  out  1  high in SPAN_WAIT
- o_spanning_in_progress  out  1  high in SPAN_READY
- o_spanning_buffer  out  16  first half of the spanning instruction
- o_spanning_second_half  out  16  second half of the spanning instruction
- o_use_buffer_after_spanning  out  1  the next parcel comes from o_instr_buffer after a span
- o_span_fetch_req  out  1  single-cycle pulse: fetch the word at (PC & ~3)+4
- o_pc_increment  out  3  combinational PC advance: 0, 2 or 4

Behaviour:
- Reset (async, i_rst_n=0):
  - All registered outputs are 0; state=NORMAL; wait counter=0.
  - o_pc_increment=0 while in reset.
- advance = !i_stall && !i_flush.
- Priority: flush > stall > advance.
- States are NORMAL, SPAN_WAIT and SPAN_READY.
- NORMAL on advance:
  - pc[1]=0 and compressed: prev_lo<=1; instr_buffer<=i_effective_instr; pc_inc=2.
  - pc[1]=1 and compressed: prev_lo<=0; pc_inc=2.
  - pc[1]=0 and 32-bit: prev_lo<=0; pc_inc=4.
  - pc[1]=1 and 32-bit (span start):
    - spanning_buffer<=i_effective_instr[31:16]; prev_lo<=0.
    - o_span_fetch_req=1 this cycle; pc_inc=0.
    - Counter<=SPAN_WAIT_CYCLES-1; state->SPAN_WAIT.
  - use_buffer_after_spanning clears on any NORMAL advance.
- SPAN_WAIT:
  - o_spanning_wait_for_fetch=1; pc_inc=0.
  - Counter decrements on each advance.
  - On an advance with counter==0: spanning_second_half<=i_instr[15:0]; instr_buffer<=i_instr; state->SPAN_READY.
- SPAN_READY:
  - o_spanning_in_progress=1.
  - On advance: pc_inc=4; use_buffer_after_spanning<=1; prev_lo<=0; state->NORMAL.
  - The new PC has pc[1]=1; its parcel is instr_buffer[31:16].
- Stall:
  - stall_registered<=i_stall every cycle, including during flush.
  - On stall entry (i_stall && !stall_registered): prev_lo_saved<=prev_lo.
  - All other state holds while stalled; o_span_fetch_req=0 and pc_inc=0 while stalled.
  - If a stall arrives mid SPAN_WAIT, the counter freezes. Memory must hold i_instr stable for the duration of the stall.
- Flush (any state):
  - Next state=NORMAL.
  - prev_lo, prev_lo_saved, use_buffer_after_spanning and counter are cleared to 0.
  - spanning regs are cleared to 0; instr_buffer is held.
  - Outputs o_span_fetch_req=0 and pc_inc=0.
- Flush+stall in the same cycle: flush applies.
- A spanning start at the upper half of the buffered word is legal: spanning_buffer comes from i_effective_instr.
- Invariant: at most one of o_spanning_wait_for_fetch and o_spanning_in_progress is high.
- SVA: o_span_fetch_req implies state==NORMAL.

Decomposition:
- Package if_c_ext_pkg holds:
  - the align_state_e enum {NORMAL, SPAN_WAIT, SPAN_READY};
  - constants PC_INC_NONE=0, PC_INC_HALF=2, PC_INC_WORD=4;
  - RVC_OPCODE_32BIT=2'b11.
- No sub-module is required. An optional small span_wait_counter can be split out if SPAN_WAIT_CYCLES grows.

Test Plan:
- Two consecutive compressed instructions: pc=0x100 then 0x102, i_instr=0x4501_4505, compressed=1 both times.
  - Cycle 1: pc_inc=2, prev_lo->1, instr_buffer=0x4501_4505.
  - Cycle 2: pc_inc=2, prev_lo->0.
- Span with SPAN_WAIT_CYCLES=1: pc=0x102, effective[31:16]=0x0513, 32-bit.
  - span_fetch_req pulses once and spanning_buffer=0x0513.
  - Next cycle: wait_for_fetch=1; i_instr=0xABCD_0045 gives second_half=0x0045.
  - SPAN_READY: in_progress=1, then pc_inc=4 and use_buffer_after_spanning=1.
- Stall entry with prev_lo=1: stall 3 cycles.
  - prev_lo_saved=1; all state frozen; pc_inc=0.
  - On release: stall_registered stays 1 for one cycle, then returns to 0.
- Flush during SPAN_WAIT with SPAN_WAIT_CYCLES=3, asserted at counter=1:
  - Next cycle: state NORMAL, wait_for_fetch=0, spanning regs=0, prev_lo=0.
- Async reset mid SPAN_READY: i_rst_n low without a clock edge.
  - All registered outputs go to 0 immediately; state NORMAL after release.
- Stall and flush asserted together in SPAN_READY:
  - Flush wins: state NORMAL, pc_inc=0, stall_registered=1 next cycle.
